seg_scan_controller: RTL
========================

// Module: seg_scan_controller
// PURPOSE
//  Parametrised multiplexed 7-segment scan controller; successor to the fixed
//  6-digit controller. Drives N_DIGITS digits from packed hex/BCD nibbles with
//  per-digit decimal points, optional leading-zero blanking, an anti-ghosting
//  guard interval, and a double-buffered load so a frame never shows mixed data.
// PARAMETERS
//  N_DIGITS     6     number of digits scanned (>=1)
//  DWELL        1000  clk cycles each digit is lit (>=1)
//  GUARD        0     clk cycles all digits dark between digits (0 = no guard)
//  SEG_ACT_LOW  0     1 = seg pins active-low (logical value inverted at pin)
//  SEL_ACT_LOW  1     1 = seg_sel pins active-low
// PORTS
//  clk        in   1           system clock
//  reset      in   1           synchronous, active-high reset
//  load       in   1           capture data/dp_in this cycle
//  data       in   4*N_DIGITS  nibble i = digit i; digit 0 = rightmost (seg_sel[0])
//  dp_in      in   N_DIGITS    decimal point per digit, 1 = lit
//  lz_en      in   1           1 = blank leading zeros (sampled live)
//  seg        out  8           {dp,g,f,e,d,c,b,a}
//  seg_sel    out  N_DIGITS    one-hot digit enable (polarity per SEL_ACT_LOW)
//  frame_tick out  1           1-cycle pulse at each frame boundary
// BEHAVIOUR
//  - One clock; reset synchronous, active-high. All outputs registered.
//  - Reset: idx=0, FSM=SHOW, dwell counter=0, active and pending buffers=0,
//    pend flag=0; seg and seg_sel driven "all off" (polarity applied),
//    frame_tick=0. Reset mid-frame aborts scan; resume at digit 0 next cycle.
//  - FSM SHOW: lights digit idx for DWELL cycles; then GUARD if GUARD>0, else
//    next digit's SHOW. GUARD: seg_sel all inactive, seg all off for GUARD
//    cycles; then SHOW of next digit. idx wraps N_DIGITS-1 -> 0.
//  - Pins lag FSM state by exactly 1 cycle. Frame = N_DIGITS*(DWELL+GUARD).
//  - Frame boundary = last cycle of the final interval of digit N_DIGITS-1;
//    frame_tick asserted on pins the cycle digit 0 SHOW first appears.
//  - Load: load=1 copies data/dp_in into pending, sets pend. At frame
//    boundary, if pend: active<=pending, pend<=0. load on the boundary cycle
//    itself: active<=data/dp_in directly, pend<=0. Multiple loads within a
//    frame: last wins. Displayed data never changes mid-frame.
//  - Decode: nibble 0-F -> standard hex glyphs (b,d lowercase); dp = active dp bit.
//  - Leading zeros: with lz_en=1, digit i (i>0) is blanked (a-g off) when its
//    nibble and every higher nibble are 0; digit 0 never blanked; dp unaffected.
//  - N_DIGITS=1: every boundary is a frame boundary; idx constant 0.
//  - Counter width $clog2(max(DWELL,GUARD)+1); no overflow beyond terminal count.
// TESTING
//  - Reset: N=4,DWELL=4,GUARD=1; hold reset 3 cycles -> seg=8'h00, seg_sel=4'hF,
//    frame_tick=0; first cycle after release still off, then seg_sel=4'hE.
//  - Scan order: same params -> seg_sel E(4 cyc),F(1),D(4),F(1),B(4),F(1),7(4),F(1),
//    repeat; frame_tick every 20 cycles, coincident with first E cycle.
//  - Deferred load: data=16'h1234 loaded mid digit 1 -> current frame unchanged;
//    next frame digit0 seg=8'h66 ('4'), digit3 seg=8'h06 ('1').
//  - Boundary load + multiple loads: loads of 0x1111 then 0x2222 in one frame ->
//    0x2222 shown; load 0x5A5A on boundary cycle -> 0x5A5A in the starting frame.
//  - Leading zeros: data=16'h0070, lz_en=1 -> digits 3,2 seg=00, digit1 '7'
//    (8'h07), digit0 '0' (8'h3F); dp_in=4'b1000 -> digit3 seg=8'h80.
//  - Polarity/reset mid-frame: SEG_ACT_LOW=1 -> seg inverted; reset asserted in
//    digit 2 -> outputs off next cycle, scan restarts at digit 0, buffers cleared.

Source files
------------

// File: rtl/seg_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_controller
// Brief    : Multiplexed N-digit 7-segment scanner with guard interval,
//            leading-zero blanking and frame-synchronous double-buffered load.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_controller #(
    parameter int N_DIGITS    = 6,
    parameter int DWELL       = 1000,
    parameter int GUARD       = 0,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit SEL_ACT_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   data,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    lz_en,
    output logic [7:0]              seg,
    output logic [N_DIGITS-1:0]     seg_sel,
    output logic                    frame_tick
);

    localparam int c_CNT_MAX = (DWELL > GUARD) ? DWELL : GUARD;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);
    localparam int c_IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam bit c_HAS_GUARD = (GUARD > 0);

    localparam logic [c_CW-1:0]     c_DWELL_END = c_CW'(DWELL - 1);
    localparam logic [c_CW-1:0]     c_GUARD_END = c_CW'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [c_IW-1:0]     c_LAST_IDX  = c_IW'(N_DIGITS - 1);
    localparam logic [7:0]          c_SEG_OFF   = {8{SEG_ACT_LOW}};
    localparam logic [N_DIGITS-1:0] c_SEL_OFF   = {N_DIGITS{SEL_ACT_LOW}};

    typedef enum logic [0:0] {
        ST_SHOW  = 1'b0,
        ST_GUARD = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_IW-1:0]        r_idx;
    logic [c_IW-1:0]        w_idx_nxt;
    logic [c_IW-1:0]        w_idx_wrap;
    logic [c_CW-1:0]        r_cnt;
    logic [c_CW-1:0]        w_cnt_nxt;
    logic                   w_boundary;
    logic                   r_frame_start;

    logic [4*N_DIGITS-1:0]  r_active_data;
    logic [N_DIGITS-1:0]    r_active_dp;
    logic [4*N_DIGITS-1:0]  r_pend_data;
    logic [N_DIGITS-1:0]    r_pend_dp;
    logic                   r_pend;

    logic [N_DIGITS-1:0]    w_zero_from;
    logic [3:0]             w_cur_nib;
    logic                   w_cur_dp;
    logic                   w_cur_zero;
    logic                   w_blank;
    logic [7:0]             w_seg_log;
    logic [N_DIGITS-1:0]    w_sel_log;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_SHOW;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_cnt         <= w_cnt_nxt;
            r_frame_start <= w_boundary;
        end
    end

    assign w_idx_wrap = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_boundary  = 1'b0;
        case (r_state)
            ST_SHOW: begin
                if (r_cnt == c_DWELL_END) begin
                    w_cnt_nxt = '0;
                    if (c_HAS_GUARD) begin
                        w_state_nxt = ST_GUARD;
                    end else begin
                        w_idx_nxt  = w_idx_wrap;
                        w_boundary = (r_idx == c_LAST_IDX);
                    end
                end
            end
            ST_GUARD: begin
                if (r_cnt == c_GUARD_END) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SHOW;
                    w_idx_nxt   = w_idx_wrap;
                    w_boundary  = (r_idx == c_LAST_IDX);
                end
            end
            default: begin
                w_state_nxt = ST_SHOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Double buffer: the active copy only changes on a frame boundary
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active_data <= '0;
            r_active_dp   <= '0;
            r_pend_data   <= '0;
            r_pend_dp     <= '0;
            r_pend        <= 1'b0;
        end else if (w_boundary) begin
            r_pend <= 1'b0;
            if (load) begin
                r_active_data <= data;
                r_active_dp   <= dp_in;
            end else if (r_pend) begin
                r_active_data <= r_pend_data;
                r_active_dp   <= r_pend_dp;
            end
        end else if (load) begin
            r_pend_data <= data;
            r_pend_dp   <= dp_in;
            r_pend      <= 1'b1;
        end
    end

    // w_zero_from[i]: nibble i and every higher nibble are zero
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_zero_from
        assign w_zero_from[gi] = (r_active_data[4*N_DIGITS-1:4*gi] == '0);
    end

    always_comb begin
        w_cur_nib  = 4'h0;
        w_cur_dp   = 1'b0;
        w_cur_zero = 1'b0;
        w_sel_log  = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == c_IW'(i)) begin
                w_cur_nib    = r_active_data[4*i +: 4];
                w_cur_dp     = r_active_dp[i];
                w_cur_zero   = w_zero_from[i];
                w_sel_log[i] = (r_state == ST_SHOW);
            end
        end
    end

    assign w_blank = lz_en && (r_idx != '0) && w_cur_zero;

    always_comb begin
        w_seg_log = 8'h00;
        if (r_state == ST_SHOW) begin
            w_seg_log = {w_cur_dp, (w_blank ? 7'h00 : hex7(w_cur_nib))};
        end
    end

    // ------------------------------------------------------------------
    // Output pins: one cycle behind the FSM, polarity applied here
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            seg        <= c_SEG_OFF;
            seg_sel    <= c_SEL_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg        <= w_seg_log ^ c_SEG_OFF;
            seg_sel    <= w_sel_log ^ c_SEL_OFF;
            frame_tick <= r_frame_start;
        end
    end

endmodule
`default_nettype wire
